uart_autobaud_ctrl: RTL and testbench
=====================================

Name: uart_autobaud_ctrl

Overview:
- Auto-baud controller for the UART x16 baud clock generator.
- On request, it measures a received 0x55 sync character on the rx line.
- From the measurement it computes the counter reload value (baud_val) and the 1/8-step fraction (baud_val_fraction), and drives both into the generator's configuration inputs.
- Sits beside the generator and the receiver, clocked by the system clock.

Parameters:
- BAUD_VAL_FRCTN_EN, 0: 1 = output fractional part; 0 = round to nearest integer, fraction forced to 0.
- DEFAULT_BAUD_VAL, 13'd25: baud_val value held from reset until the first successful lock.
- CNT_W, 21: width of the measurement counters.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- rx_in  input  1  asynchronous serial line, idle high
- start  input  1  single-cycle request to begin a measurement
- baud_val  output  13  reload value for the baud generator
- baud_val_fraction  output  3  fraction for the baud generator, in 1/8 steps
- busy  output  1  high from accepting start until done/error
- done  output  1  single-cycle pulse: new values loaded
- error  output  1  single-cycle pulse: measurement rejected
- locked  output  1  level, high after a successful measurement

Behaviour:
- One clock: clk. Reset is synchronous and active-high (reset).
- Reset values:
  - baud_val = DEFAULT_BAUD_VAL, baud_val_fraction = 0.
  - busy = done = error = locked = 0.
  - FSM in IDLE, counters 0, rx synchronizer flops = 1.
- Reset mid-measurement aborts and restores these values on the next edge.
- Input synchronization:
  - rx_in passes through a 2-flop synchronizer.
  - A falling edge is a synced sample going 1 then 0, registered against the previous synced value.
  - The constant pipeline latency cancels in all interval measurements.
- Timing model: generator period = baud_val+1+fraction/8 clks per x16 tick, so one bit = 16*(baud_val+1) + 2*fraction clks.
- 0x55 framing (start, LSB-first data, stop) gives falling edges at bit times 0, 2, 4, 6, 8. The span from the 1st to the 5th falling edge, T, is 8 bit times.
- Therefore T = 128*(B+1) + 16*F.
- FSM states:
  - IDLE:
    - busy = 0.
    - start → WAIT_IDLE: set busy, clear locked.
    - start while busy is ignored.
  - WAIT_IDLE: wait for synced rx = 1, then → WAIT_START.
  - WAIT_START:
    - On a falling edge: clear total counter T and interval counter I, edge_cnt = 1, → MEASURE.
    - No timeout in this state.
  - MEASURE:
    - T and I increment every cycle.
    - On each falling edge:
      - edge_cnt = 2: latch I1 = I.
      - edge_cnt = 3..5: check |I − I1| > (I1 >> 2) → error.
      - Clear I and increment edge_cnt.
    - On the 5th edge, latch T (the count at the edge) → CALC.
    - If T or I reaches all-ones (saturation), → ERROR (timeout).
  - CALC (exactly one cycle):
    - Compute N = T >> 4 (CNT_W−4 bits).
    - If BAUD_VAL_FRCTN_EN = 1: B = (N >> 3) − 1, F = N[2:0].
    - Else: B = ((N + 4) >> 3) − 1, F = 0.
    - Reject if N < 16 (B < 1) or B > 8191 → ERROR.
    - Otherwise → DONE.
  - DONE (one cycle):
    - Load baud_val = B[12:0] and baud_val_fraction = F.
    - Pulse done, set locked, clear busy → IDLE.
  - ERROR (one cycle):
    - Pulse error, clear busy, locked stays 0.
    - baud_val and baud_val_fraction keep their previous values → IDLE.
- Latency: done asserts 2 cycles after the clk edge that samples the 5th falling edge (MEASURE→CALC→DONE).
- baud_val and baud_val_fraction change only in DONE, and are stable at all other times.
- start coincident with DONE/ERROR is ignored. start in the cycle after done/error is accepted.

Test Plan:
- Reset, no start → baud_val = 25, baud_val_fraction = 0, locked = 0, all pulses low. Reset asserted during MEASURE → same values next cycle, busy = 0.
- FRCTN_EN = 0: start, then 0x55 at 416-clk bits (falling-edge spacing 832, T = 3328) → N = 208, done pulse, baud_val = 25, fraction = 0, locked = 1.
- FRCTN_EN = 1: 0x55 with T = 3376 (bit 422) → baud_val = 25, fraction = 3. Same stimulus with FRCTN_EN = 0 → baud_val = 25 via rounding, fraction = 0.
- Glitch: intervals 832, 832, 1100, 832 → error pulse at the 4th edge, busy drops, baud_val unchanged, locked = 0.
- Timeout: start, one falling edge, rx held low → error on counter saturation (2^21−1 cycles); too-fast line (bit = 16 clk, T = 128, N = 8) → error from CALC.
- Re-trigger: start pulses while busy are ignored (one done only); a second start after done clears locked at acceptance and re-measures a new rate (bit 208 → baud_val = 12).

Source files
------------

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: times a received 0x55 sync character on rx_in and
// derives the x16 baud generator reload value and its 1/8-step fraction.
module uart_autobaud_ctrl #(
   parameter int          BAUD_VAL_FRCTN_EN = 0,
   parameter logic [12:0] DEFAULT_BAUD_VAL  = 13'd25,
   parameter int          CNT_W             = 21
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_in,
   input  logic        start,
   output logic [12:0] baud_val,
   output logic [2:0]  baud_val_fraction,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        locked
);
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_IDLE  = 3'd1,
      S_WAIT_START = 3'd2,
      S_MEASURE    = 3'd3,
      S_CALC       = 3'd4,
      S_DONE       = 3'd5,
      S_ERROR      = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] N_MIN    = CNT_W'(16);
   localparam logic [CNT_W-1:0] B_MAX    = CNT_W'(8191);

   state_t            state_r, state_nxt_s;
   logic              rx_meta_r, rx_sync_r, rx_prev_r, fall_s;
   logic [CNT_W-1:0]  t_cnt_r, i_cnt_r, i1_r, t_lat_r;
   logic [2:0]        edge_cnt_r;
   logic [CNT_W-1:0]  t_inc_s, i_inc_s, i_diff_s, n_s, n_rnd_s, b_s;
   logic [2:0]        f_s;
   logic              sat_s, dev_bad_s, calc_ok_s;
   logic [12:0]       baud_val_r;
   logic [2:0]        frac_r;
   logic              busy_r, done_r, error_r, locked_r;

   assign fall_s            = rx_prev_r & ~rx_sync_r;
   assign baud_val          = baud_val_r;
   assign baud_val_fraction = frac_r;
   assign busy              = busy_r;
   assign done              = done_r;
   assign error             = error_r;
   assign locked            = locked_r;

   // rx_in synchronizer plus one-cycle history for falling-edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_meta_r <= rx_in;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   // Counts as seen at the current edge, interval deviation and rate arithmetic
   always_comb begin
      t_inc_s = t_cnt_r + CNT_W'(1);
      i_inc_s = i_cnt_r + CNT_W'(1);
      sat_s   = (t_inc_s == CNT_ONES) || (i_inc_s == CNT_ONES);
      if (i_inc_s > i1_r) begin
         i_diff_s = i_inc_s - i1_r;
      end else begin
         i_diff_s = i1_r - i_inc_s;
      end
      dev_bad_s = (i_diff_s > (i1_r >> 2));
      n_s       = t_lat_r >> 4;
      if (BAUD_VAL_FRCTN_EN != 0) begin
         n_rnd_s = n_s;
         f_s     = n_s[2:0];
      end else begin
         n_rnd_s = n_s + CNT_W'(4);
         f_s     = 3'd0;
      end
      b_s       = (n_rnd_s >> 3) - CNT_W'(1);
      calc_ok_s = (n_s >= N_MIN) && (b_s <= B_MAX);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; edge_cnt_r holds the number of edges already seen
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) state_nxt_s = S_WAIT_IDLE;
            else       state_nxt_s = S_IDLE;
         end
         S_WAIT_IDLE: begin
            if (rx_sync_r) state_nxt_s = S_WAIT_START;
            else           state_nxt_s = S_WAIT_IDLE;
         end
         S_WAIT_START: begin
            if (fall_s) state_nxt_s = S_MEASURE;
            else        state_nxt_s = S_WAIT_START;
         end
         S_MEASURE: begin
            if (sat_s) begin
               state_nxt_s = S_ERROR;
            end else if (fall_s) begin
               if ((edge_cnt_r >= 3'd2) && dev_bad_s) state_nxt_s = S_ERROR;
               else if (edge_cnt_r == 3'd4)           state_nxt_s = S_CALC;
               else                                   state_nxt_s = S_MEASURE;
            end else begin
               state_nxt_s = S_MEASURE;
            end
         end
         S_CALC: begin
            if (calc_ok_s) state_nxt_s = S_DONE;
            else           state_nxt_s = S_ERROR;
         end
         S_DONE:  state_nxt_s = S_IDLE;
         S_ERROR: state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Measurement counters: total span, current interval and first interval
   always_ff @(posedge clk) begin
      if (reset) begin
         t_cnt_r    <= '0;
         i_cnt_r    <= '0;
         i1_r       <= '0;
         t_lat_r    <= '0;
         edge_cnt_r <= 3'd0;
      end else begin
         case (state_r)
            S_WAIT_START: begin
               if (fall_s) begin
                  t_cnt_r    <= '0;
                  i_cnt_r    <= '0;
                  edge_cnt_r <= 3'd1;
               end
            end
            S_MEASURE: begin
               t_cnt_r <= t_inc_s;
               i_cnt_r <= i_inc_s;
               if (fall_s) begin
                  i_cnt_r    <= '0;
                  edge_cnt_r <= edge_cnt_r + 3'd1;
                  if (edge_cnt_r == 3'd1) i1_r    <= i_inc_s;
                  if (edge_cnt_r == 3'd4) t_lat_r <= t_inc_s;
               end
            end
            default: begin
               t_cnt_r <= t_cnt_r;
            end
         endcase
      end
   end

   // Registered status outputs and configuration load on a good measurement
   always_ff @(posedge clk) begin
      if (reset) begin
         baud_val_r <= DEFAULT_BAUD_VAL;
         frac_r     <= 3'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         locked_r   <= 1'b0;
      end else begin
         busy_r  <= (state_nxt_s == S_WAIT_IDLE) || (state_nxt_s == S_WAIT_START) ||
                    (state_nxt_s == S_MEASURE)   || (state_nxt_s == S_CALC);
         done_r  <= (state_nxt_s == S_DONE);
         error_r <= (state_nxt_s == S_ERROR);
         if ((state_r == S_IDLE) && start) begin
            locked_r <= 1'b0;
         end else if (state_nxt_s == S_DONE) begin
            locked_r <= 1'b1;
         end
         if ((state_r == S_CALC) && calc_ok_s) begin
            baud_val_r <= b_s[12:0];
            frac_r     <= f_s;
         end
      end
   end
endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Self-checking bench for uart_autobaud_ctrl: rounding and fractional instances
// share the line; a narrow-counter instance exercises the saturation timeout.
module tb_uart_autobaud_ctrl;
   logic        clk = 1'b0;
   logic        reset, rx_in, start, start_s;
   logic [12:0] bv [3];
   logic [2:0]  fr [3];
   logic        bz [3];
   logic        dn [3];
   logic        er [3];
   logic        lk [3];

   int total = 0;
   int bad   = 0;
   int n_done [3];
   int n_err [3];
   int n_stray [3];
   int exp_bv [3];
   int exp_fr [3];
   logic [15:0] prev_cfg [3];

   typedef struct {
      int g0, g1, g2, g3;
      bit ok0; int b0; int f0;
      bit ok1; int b1; int f1;
   } vec_t;
   vec_t tbl [8];

   uart_autobaud_ctrl #(.BAUD_VAL_FRCTN_EN(0), .DEFAULT_BAUD_VAL(13'd25), .CNT_W(21)) dut_rnd (
      .clk(clk), .reset(reset), .rx_in(rx_in), .start(start),
      .baud_val(bv[0]), .baud_val_fraction(fr[0]), .busy(bz[0]),
      .done(dn[0]), .error(er[0]), .locked(lk[0]));

   uart_autobaud_ctrl #(.BAUD_VAL_FRCTN_EN(1), .DEFAULT_BAUD_VAL(13'd25), .CNT_W(21)) dut_frc (
      .clk(clk), .reset(reset), .rx_in(rx_in), .start(start),
      .baud_val(bv[1]), .baud_val_fraction(fr[1]), .busy(bz[1]),
      .done(dn[1]), .error(er[1]), .locked(lk[1]));

   uart_autobaud_ctrl #(.BAUD_VAL_FRCTN_EN(0), .DEFAULT_BAUD_VAL(13'd25), .CNT_W(13)) dut_sat (
      .clk(clk), .reset(reset), .rx_in(rx_in), .start(start_s),
      .baud_val(bv[2]), .baud_val_fraction(fr[2]), .busy(bz[2]),
      .done(dn[2]), .error(er[2]), .locked(lk[2]));

   always #5 clk = ~clk;

   // Pulse counters and detection of configuration changes outside a done pulse
   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         if (dn[k] === 1'b1) n_done[k]++;
         if (er[k] === 1'b1) n_err[k]++;
         if (reset !== 1'b1 && dn[k] !== 1'b1 && {bv[k], fr[k]} !== prev_cfg[k]) n_stray[k]++;
         prev_cfg[k] = {bv[k], fr[k]};
      end
   end

   task automatic check(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   task automatic drive(input logic v, input int n);
      rx_in = v;
      repeat (n) @(negedge clk);
   endtask

   // A 0x55 frame generalised to arbitrary falling-edge spacings
   task automatic send_frame(input int g [4]);
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, g[k] / 2);
         drive(1'b1, g[k] - g[k] / 2);
      end
      drive(1'b0, g[0] / 2);
      drive(1'b1, 30);
   endtask

   // Reference: span T is the sum of the spacings, rate derived from T/16
   task automatic model(input int g [4], input bit frac, output bit ok, output int b, output int f);
      int t, n, d;
      ok = 1'b1;
      t  = g[0];
      for (int k = 1; k < 4; k++) begin
         t = t + g[k];
         d = (g[k] > g[0]) ? g[k] - g[0] : g[0] - g[k];
         if (d > g[0] / 4) ok = 1'b0;
      end
      n = t / 16;
      if (frac) begin
         b = n / 8 - 1;
         f = n % 8;
      end else begin
         b = (n + 4) / 8 - 1;
         f = 0;
      end
      if (n < 16 || b > 8191) ok = 1'b0;
   endtask

   task automatic check_unit(input string nm, input int k, input int dd, input int de, input bit ok);
      check({nm, $sformatf(".done%0d", k)}, dd, ok ? 1 : 0);
      check({nm, $sformatf(".error%0d", k)}, de, ok ? 0 : 1);
      check({nm, $sformatf(".baud_val%0d", k)}, int'(bv[k]), exp_bv[k]);
      check({nm, $sformatf(".fraction%0d", k)}, int'(fr[k]), exp_fr[k]);
      check({nm, $sformatf(".locked%0d", k)}, int'(lk[k]), ok ? 1 : 0);
      check({nm, $sformatf(".busy%0d", k)}, int'(bz[k]), 0);
   endtask

   task automatic measure(input int g0, g1, g2, g3, input bit ok0, input int b0, f0,
                          input bit ok1, input int b1, f1, input string nm);
      int g [4];
      int d0, e0, d1, e1;
      g  = '{g0, g1, g2, g3};
      d0 = n_done[0]; e0 = n_err[0]; d1 = n_done[1]; e1 = n_err[1];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive(1'b1, 4);
      send_frame(g);
      if (ok0) begin exp_bv[0] = b0; exp_fr[0] = f0; end
      if (ok1) begin exp_bv[1] = b1; exp_fr[1] = f1; end
      check_unit(nm, 0, n_done[0] - d0, n_err[0] - e0, ok0);
      check_unit(nm, 1, n_done[1] - d1, n_err[1] - e1, ok1);
   endtask

   initial begin
      int g [4];
      int d0, w;
      reset   = 1'b1;
      rx_in   = 1'b1;
      start   = 1'b0;
      start_s = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         exp_bv[k] = 25;
         exp_fr[k] = 0;
         check($sformatf("reset.baud_val%0d", k), int'(bv[k]), 25);
         check($sformatf("reset.fraction%0d", k), int'(fr[k]), 0);
         check($sformatf("reset.locked%0d", k), int'(lk[k]), 0);
         check($sformatf("reset.busy%0d", k), int'(bz[k]), 0);
         check($sformatf("reset.pulses%0d", k), n_done[k] + n_err[k], 0);
      end

      tbl[0] = '{832, 832, 832, 832,   1'b1, 25, 0, 1'b1, 25, 0};
      tbl[1] = '{844, 844, 844, 844,   1'b1, 25, 0, 1'b1, 25, 3};
      tbl[2] = '{848, 848, 848, 848,   1'b1, 26, 0, 1'b1, 25, 4};
      tbl[3] = '{832, 832, 1100, 832,  1'b0, 0, 0,  1'b0, 0, 0};
      tbl[4] = '{32, 32, 32, 32,       1'b0, 0, 0,  1'b0, 0, 0};
      tbl[5] = '{832, 832, 1040, 832,  1'b1, 27, 0, 1'b1, 26, 5};
      tbl[6] = '{832, 832, 1041, 832,  1'b0, 0, 0,  1'b0, 0, 0};
      tbl[7] = '{416, 416, 416, 416,   1'b1, 12, 0, 1'b1, 12, 0};
      for (int i = 0; i < 8; i++) begin
         measure(tbl[i].g0, tbl[i].g1, tbl[i].g2, tbl[i].g3,
                 tbl[i].ok0, tbl[i].b0, tbl[i].f0, tbl[i].ok1, tbl[i].b1, tbl[i].f1,
                 $sformatf("vec%0d", i));
      end

      for (int r = 0; r < 10; r++) begin
         int base, j;
         bit o0, o1;
         int b0, f0, b1, f1;
         base = 2 * $urandom_range(20, 300);
         g[0] = base;
         for (int k = 1; k < 4; k++) begin
            if ($urandom_range(0, 3) == 0) j = $urandom_range(0, base / 2);
            else                           j = $urandom_range(0, base / 8);
            g[k] = ($urandom_range(0, 1) == 1) ? base + j : base - j;
         end
         model(g, 1'b0, o0, b0, f0);
         model(g, 1'b1, o1, b1, f1);
         measure(g[0], g[1], g[2], g[3], o0, b0, f0, o1, b1, f1, $sformatf("rand%0d", r));
      end

      // start while busy is ignored: exactly one done for the frame
      g  = '{832, 832, 832, 832};
      d0 = n_done[0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive(1'b1, 4);
      fork
         send_frame(g);
         begin
            repeat (200) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      check("retrig.done_count", n_done[0] - d0, 1);
      check("retrig.baud_val", int'(bv[0]), 25);
      check("retrig.locked", int'(lk[0]), 1);
      exp_bv[0] = 25; exp_fr[0] = 0; exp_bv[1] = 25; exp_fr[1] = 0;

      // a new start clears locked on acceptance, then re-measures
      d0 = n_done[0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("restart.locked_cleared", int'(lk[0]), 0);
      check("restart.busy", int'(bz[0]), 1);
      drive(1'b1, 4);
      g = '{416, 416, 416, 416};
      send_frame(g);
      check("restart.done_count", n_done[0] - d0, 1);
      check("restart.baud_val", int'(bv[0]), 12);
      check("restart.locked", int'(lk[0]), 1);

      // reset in the middle of MEASURE
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drive(1'b1, 4);
      drive(1'b0, 50);
      drive(1'b1, 50);
      drive(1'b0, 20);
      check("midreset.busy_before", int'(bz[0]), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rx_in = 1'b1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("midreset.baud_val%0d", k), int'(bv[k]), 25);
         check($sformatf("midreset.fraction%0d", k), int'(fr[k]), 0);
         check($sformatf("midreset.busy%0d", k), int'(bz[k]), 0);
         check($sformatf("midreset.locked%0d", k), int'(lk[k]), 0);
      end
      drive(1'b1, 10);

      // one falling edge then a stuck-low line: counter saturation on a 13-bit instance
      d0 = n_err[2];
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      drive(1'b1, 4);
      rx_in = 1'b0;
      w = 0;
      while (n_err[2] == d0 && w < 9000) begin
         @(negedge clk);
         w++;
      end
      check("timeout.error_count", n_err[2] - d0, 1);
      check("timeout.in_window", (w > 8000 && w < 9000) ? 1 : 0, 1);
      drive(1'b1, 10);
      check("timeout.baud_val", int'(bv[2]), 25);
      check("timeout.locked", int'(lk[2]), 0);
      check("timeout.busy", int'(bz[2]), 0);
      check("timeout.no_done", n_done[2], 0);

      for (int k = 0; k < 3; k++) begin
         check($sformatf("stable_cfg%0d", k), n_stray[k], 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
